uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched_pkg.sv | 18 +
 rtl/uart_rr_pick.sv | 26 ++
 rtl/uart_tx_sched.sv | 106 ++++++++++
 tb/tb_uart_tx_sched.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_sched_pkg.sv
// Shared constants, FSM state encoding and helpers for the UART byte scheduler.
package uart_tx_sched_pkg;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD       = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } state_e;

  function automatic logic [NREQ-1:0] id2oh(input logic [IDW-1:0] id);
    logic [NREQ-1:0] one;
    one = {{(NREQ-1){1'b0}}, 1'b1};
    return one << id;
  endfunction
endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first asserted request at or after pointer p, ascending mod NREQ.
module uart_rr_pick
  import uart_tx_sched_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  p,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  // Scan from farthest to nearest offset so the nearest hit overwrites the rest.
  always_comb begin
    logic [IDW-1:0] cand;
    any  = 1'b0;
    idx  = p;
    cand = p;
    for (int k = NREQ-1; k >= 0; k--) begin
      cand = p + IDW'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin byte scheduler feeding a UART transmit unit.
// Optional requester lock (re-grant last winner) enabled by UART_TX_SCHED_LOCK_EN.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NREQ = uart_tx_sched_pkg::NREQ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
`ifdef UART_TX_SCHED_LOCK_EN
  input  logic [NREQ-1:0]   req_lock,
`endif
  output logic [NREQ-1:0]   ack,
  output logic              tx_load,
  output logic [7:0]        tx_data,
  input  logic              tx_ts,
  output logic              busy,
  output logic [IDW-1:0]    cur_id
);

  state_e         state_q, state_d;
  logic [IDW-1:0] p_q, p_d;
  logic [IDW-1:0] cur_id_q, cur_id_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           rr_any;
  logic [IDW-1:0] rr_idx;

  uart_rr_pick u_pick (
    .req (req),
    .p   (p_q),
    .any (rr_any),
    .idx (rr_idx)
  );

`ifdef UART_TX_SCHED_LOCK_EN
  // cur_id only means "last winner" once a real grant happened since reset.
  logic gv_q, gv_d;
  logic lock_hit;
  assign lock_hit = gv_q && req_lock[cur_id_q] && req[cur_id_q];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      p_q       <= '0;
      cur_id_q  <= '0;
      tx_data_q <= '0;
`ifdef UART_TX_SCHED_LOCK_EN
      gv_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      cur_id_q  <= cur_id_d;
      tx_data_q <= tx_data_d;
`ifdef UART_TX_SCHED_LOCK_EN
      gv_q      <= gv_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    cur_id_d  = cur_id_q;
    tx_data_d = tx_data_q;
`ifdef UART_TX_SCHED_LOCK_EN
    gv_d      = gv_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
`ifdef UART_TX_SCHED_LOCK_EN
        if (tx_ts && lock_hit) begin
          state_d   = ST_LOAD;
          tx_data_d = req_data[cur_id_q*8 +: 8];
        end else
`endif
        if (tx_ts && rr_any) begin
          state_d   = ST_LOAD;
          cur_id_d  = rr_idx;
          p_d       = rr_idx + 1'b1;
          tx_data_d = req_data[rr_idx*8 +: 8];
`ifdef UART_TX_SCHED_LOCK_EN
          gv_d      = 1'b1;
`endif
        end
      end
      ST_LOAD:       state_d = ST_WAIT_START;
      ST_WAIT_START: if (!tx_ts) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE:  if (tx_ts)  state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_load = (state_q == ST_LOAD);
    ack     = tx_load ? id2oh(cur_id_q) : '0;
    busy    = (state_q != ST_IDLE);
  end

  assign tx_data = tx_data_q;
  assign cur_id  = cur_id_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched; lock scenario runs when UART_TX_SCHED_LOCK_EN is defined.
module tb_uart_tx_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic        tx_load;
  logic [7:0]  tx_data;
  logic        tx_ts;
  logic        busy;
  logic [1:0]  cur_id;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  always #5 clk = ~clk;

`ifdef UART_TX_SCHED_LOCK_EN
  logic [3:0] req_lock;
  uart_tx_sched dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_lock(req_lock),
    .ack(ack), .tx_load(tx_load), .tx_data(tx_data), .tx_ts(tx_ts),
    .busy(busy), .cur_id(cur_id)
  );
`else
  uart_tx_sched dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack), .tx_load(tx_load), .tx_data(tx_data), .tx_ts(tx_ts),
    .busy(busy), .cur_id(cur_id)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // From LOAD: step through WAIT_START, WAIT_DONE and back to IDLE.
  task automatic finish_tx();
    tick();
    tx_ts = 1'b0;
    tick();
    tx_ts = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    req = 4'b0000; req_data = 32'hFFFF_FFFF; tx_ts = 1'b1;
    rst = 1'b0;
    tick();
    total_cnt++;
    if ({busy, tx_load, ack, cur_id, tx_data} !== 16'h0000)
      $display("FAIL reset_state got busy=%b load=%b ack=%b id=%0d data=%h want all 0",
               busy, tx_load, ack, cur_id, tx_data);
    else pass_cnt++;
    rst = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001; req_data = 32'h0000_0055; tx_ts = 1'b1;
    tick();
    total_cnt++;
    if ({tx_load, ack, tx_data, cur_id, busy} !== {1'b1, 4'b0001, 8'h55, 2'd0, 1'b1})
      $display("FAIL single_grant got load=%b ack=%b data=%h id=%0d busy=%b want 1 0001 55 0 1",
               tx_load, ack, tx_data, cur_id, busy);
    else pass_cnt++;
    req = 4'b0000;
    tick();
    tick();
    total_cnt++;
    if ({tx_load, ack, busy} !== 6'b0_0000_1)
      $display("FAIL single_wait_start got load=%b ack=%b busy=%b want 0 0000 1", tx_load, ack, busy);
    else pass_cnt++;
    tx_ts = 1'b0;
    tick();
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL single_wait_done got busy=%b want 1", busy);
    else pass_cnt++;
    tx_ts = 1'b1;
    tick();
    total_cnt++;
    if ({busy, tx_load} !== 2'b00) $display("FAIL single_idle got busy=%b load=%b want 0 0", busy, tx_load);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ids [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    req = 4'b1111; req_data = 32'hA3A2_A1A0; tx_ts = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      total_cnt++;
      if ({tx_load, ack, tx_data} !== {1'b1, 4'b0001 << exp_ids[n], 8'hA0 + 8'(exp_ids[n])})
        $display("FAIL rr_grant%0d got load=%b ack=%b data=%h want load=1 id=%0d", n,
                 tx_load, ack, tx_data, exp_ids[n]);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({tx_load, ack} !== 5'b0) $display("FAIL rr_single_load%0d got load=%b ack=%b want 0 0000", n, tx_load, ack);
      else pass_cnt++;
      tx_ts = 1'b0;
      tick();
      tx_ts = 1'b1;
      tick();
    end
    req = 4'b0000;
  endtask

  task automatic test_ts_hold();
    tx_ts = 1'b0; req = 4'b0010; req_data = 32'h0000_3C00;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      tick();
      total_cnt++;
      if ({tx_load, ack} !== 5'b0) $display("FAIL ts_hold%0d got load=%b ack=%b want 0 0000", n, tx_load, ack);
      else pass_cnt++;
    end
    tx_ts = 1'b1;
    tick();
    total_cnt++;
    if ({tx_load, ack, tx_data} !== {1'b1, 4'b0010, 8'h3C})
      $display("FAIL ts_release got load=%b ack=%b data=%h want 1 0010 3c", tx_load, ack, tx_data);
    else pass_cnt++;
    req = 4'b0000;
    finish_tx();
  endtask

  task automatic test_drop();
    int bad;
    bad = 0;
    tx_ts = 1'b0; req = 4'b0100; req_data = 32'h0077_0000;
    tick(); tick();
    req = 4'b0000;
    tick();
    tx_ts = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (tx_load !== 1'b0 || ack !== 4'b0000) bad++;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL drop_req got %0d cycles with load/ack want 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100; req_data = 32'h0099_0000; tx_ts = 1'b1;
    tick();
    total_cnt++;
    if (ack !== 4'b0100) $display("FAIL mid_first_grant got ack=%b want 0100", ack);
    else pass_cnt++;
    req = 4'b0000;
    tick();
    tx_ts = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    total_cnt++;
    if ({busy, tx_load, ack} !== 6'b0) $display("FAIL mid_reset got busy=%b load=%b ack=%b want 0 0 0000", busy, tx_load, ack);
    else pass_cnt++;
    rst = 1'b1; tx_ts = 1'b1; req = 4'b1111; req_data = 32'hA3A2_A1A0;
    tick();
    total_cnt++;
    if ({ack, tx_data} !== {4'b0001, 8'hA0}) $display("FAIL mid_regrant got ack=%b data=%h want 0001 a0", ack, tx_data);
    else pass_cnt++;
    req = 4'b0000;
    finish_tx();
  endtask

`ifdef UART_TX_SCHED_LOCK_EN
  task automatic test_lock();
    req_lock = 4'b0001;
    do_reset();
    req = 4'b0011; req_data = 32'h0000_B1B0; tx_ts = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      total_cnt++;
      if (ack !== 4'b0001) $display("FAIL lock_grant%0d got ack=%b want 0001", n, ack);
      else pass_cnt++;
      finish_tx();
    end
    req_lock = 4'b0000;
    tick();
    total_cnt++;
    if ({ack, tx_data} !== {4'b0010, 8'hB1}) $display("FAIL lock_release got ack=%b data=%h want 0010 b1", ack, tx_data);
    else pass_cnt++;
    req = 4'b0000;
    finish_tx();
  endtask
`endif

  initial begin
    rst = 1'b1; req = '0; req_data = '0; tx_ts = 1'b1;
`ifdef UART_TX_SCHED_LOCK_EN
    req_lock = '0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_ts_hold();
    test_drop();
    test_reset_mid();
`ifdef UART_TX_SCHED_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
